// File: rtl/adpll_lock_ctrl.sv
// adpll_lock_ctrl
//   Lock detector and gain scheduler for the ADPLL PI loop filter. Watches the
//   phase-error magnitude once per reference period. It drives the
//   acquisition gains until lock is found, waits out a settle window after
//   switching to the tracking gains, and then declares lock. A run of bad
//   periods while locked drops the loop back to acquisition.
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   enable              level; 0 freezes the controller in IDLE with zero gains
//   ref_tick            one-clk pulse per reference period (clk domain)
//   err_mag[W]          unsigned phase-error magnitude, sampled on ref_tick
//   alpha/beta_acq[W]   acquisition gain set
//   alpha/beta_trk[W]   tracking gain set
//   alpha/beta_out[W]   registered gains to the filter
//   state[2]            IDLE=0, ACQ=1, SETTLE=2, LOCKED=3
//   locked              high only in LOCKED
//   gain_upd            pulse in the cycle the output gains take a new set
//   lock_lost           pulse on LOCKED->ACQ
module adpll_lock_ctrl #(
  parameter int W          = 5,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_CNT   = 16,
  parameter int SETTLE_CNT = 8,
  parameter int UNLOCK_TOL = 6,
  parameter int UNLOCK_CNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         ref_tick,
  input  logic [W-1:0] err_mag,
  input  logic [W-1:0] alpha_acq,
  input  logic [W-1:0] beta_acq,
  input  logic [W-1:0] alpha_trk,
  input  logic [W-1:0] beta_trk,
  output logic [W-1:0] alpha_out,
  output logic [W-1:0] beta_out,
  output logic [1:0]   state,
  output logic         locked,
  output logic         gain_upd,
  output logic         lock_lost
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(SETTLE_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  typedef struct packed {
    logic [W-1:0] alpha;
    logic [W-1:0] beta;
  } gains_t;

  state_t        st_q, st_d;
  gains_t        g_q, g_d;
  logic          locked_d, upd_d, lost_d;
  logic [GW-1:0] good_cnt, good_d;
  logic [SW-1:0] set_cnt, set_d;
  logic [BW-1:0] bad_cnt, bad_d;

  assign state     = st_q;
  assign alpha_out = g_q.alpha;
  assign beta_out  = g_q.beta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= IDLE;
      g_q       <= '0;
      locked    <= 1'b0;
      gain_upd  <= 1'b0;
      lock_lost <= 1'b0;
      good_cnt  <= '0;
      set_cnt   <= '0;
      bad_cnt   <= '0;
    end else begin
      st_q      <= st_d;
      g_q       <= g_d;
      locked    <= locked_d;
      gain_upd  <= upd_d;
      lock_lost <= lost_d;
      good_cnt  <= good_d;
      set_cnt   <= set_d;
      bad_cnt   <= bad_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    g_d      = g_q;
    locked_d = locked;
    upd_d    = 1'b0;
    lost_d   = 1'b0;
    good_d   = good_cnt;
    set_d    = set_cnt;
    bad_d    = bad_cnt;

    if (!enable) begin
      // Freeze wins over any same-cycle tick. Only flag an update if the
      // filter actually sees its gains change.
      st_d     = IDLE;
      g_d      = '0;
      locked_d = 1'b0;
      upd_d    = |g_q;
      good_d   = '0;
      set_d    = '0;
      bad_d    = '0;
    end else begin
      case (st_q)
        IDLE: begin
          // A tick arriving here is not sampled. Error sampling starts in ACQ.
          st_d   = ACQ;
          g_d    = '{alpha: alpha_acq, beta: beta_acq};
          upd_d  = 1'b1;
          good_d = '0;
        end
        ACQ: begin
          if (ref_tick) begin
            if (err_mag <= W'(LOCK_TOL)) begin
              // Compare against threshold-1 so the counter never has to hold LOCK_CNT.
              if (good_cnt == GW'(LOCK_CNT - 1)) begin
                st_d   = SETTLE;
                g_d    = '{alpha: alpha_trk, beta: beta_trk};
                upd_d  = 1'b1;
                good_d = '0;
                set_d  = '0;
              end else begin
                good_d = good_cnt + 1'b1;
              end
            end else begin
              good_d = '0;
            end
          end
        end
        SETTLE: begin
          if (ref_tick) begin
            if (set_cnt == SW'(SETTLE_CNT - 1)) begin
              st_d     = LOCKED;
              locked_d = 1'b1;
              set_d    = '0;
              bad_d    = '0;
            end else begin
              set_d = set_cnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (ref_tick) begin
            if (err_mag > W'(UNLOCK_TOL)) begin
              if (bad_cnt == BW'(UNLOCK_CNT - 1)) begin
                st_d     = ACQ;
                g_d      = '{alpha: alpha_acq, beta: beta_acq};
                upd_d    = 1'b1;
                lost_d   = 1'b1;
                locked_d = 1'b0;
                bad_d    = '0;
                good_d   = '0;
              end else begin
                bad_d = bad_cnt + 1'b1;
              end
            end else begin
              bad_d = '0;
            end
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Scoreboard bench for adpll_lock_ctrl. Each driven cycle pushes the
// hand-derived post-edge outputs. A monitor pops and compares them 1 ns
// after every rising edge.
module tb_adpll_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       ref_tick = 1'b0;
  logic [4:0] err_mag = '0;
  logic [4:0] alpha_acq = 5'd8, beta_acq = 5'd12;
  logic [4:0] alpha_trk = 5'd2, beta_trk = 5'd3;
  logic [4:0] alpha_out, beta_out;
  logic [1:0] state;
  logic       locked, gain_upd, lock_lost;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adpll_lock_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .ref_tick(ref_tick), .err_mag(err_mag),
    .alpha_acq(alpha_acq), .beta_acq(beta_acq), .alpha_trk(alpha_trk), .beta_trk(beta_trk),
    .alpha_out(alpha_out), .beta_out(beta_out), .state(state), .locked(locked),
    .gain_upd(gain_upd), .lock_lost(lock_lost)
  );

  typedef struct {
    logic [1:0] st;
    logic [4:0] a;
    logic [4:0] b;
    logic       lk;
    logic       up;
    logic       ll;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic [1:0] s, logic [4:0] a, logic [4:0] b,
                              logic lk, logic up, logic ll);
    exp_t e;
    e.st = s; e.a = a; e.b = b; e.lk = lk; e.up = up; e.ll = ll;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("state",     32'(state),     32'(mon_e.st));
      chk("alpha_out", 32'(alpha_out), 32'(mon_e.a));
      chk("beta_out",  32'(beta_out),  32'(mon_e.b));
      chk("locked",    32'(locked),    32'(mon_e.lk));
      chk("gain_upd",  32'(gain_upd),  32'(mon_e.up));
      chk("lock_lost", 32'(lock_lost), 32'(mon_e.ll));
    end
  end

  // One clock: drive at the falling edge, expect e after the next rising edge.
  task automatic cyc(input logic en, input logic tk, input logic [4:0] err, input exp_t e);
    @(negedge clk);
    enable = en; ref_tick = tk; err_mag = err;
    q.push_back(e);
    @(posedge clk);
  endtask

  // n non-deciding ticks, each followed by an idle gap cycle; outputs hold at e.
  task automatic ticks(input int n, input logic [4:0] err, input exp_t e);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b1, err, e);
      cyc(1'b1, 1'b0, err, e);
    end
  endtask

  initial begin
    exp_t I, A, S, L, S9;
    I  = mk(2'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0);
    A  = mk(2'd1, 5'd8, 5'd12, 1'b0, 1'b0, 1'b0);
    S  = mk(2'd2, 5'd2, 5'd3,  1'b0, 1'b0, 1'b0);
    L  = mk(2'd3, 5'd2, 5'd3,  1'b1, 1'b0, 1'b0);
    S9 = mk(2'd2, 5'd9, 5'd3,  1'b0, 1'b0, 1'b0);

    // Reset values, then disabled ticks do nothing.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_alpha", 32'(alpha_out), 32'd0);
    chk("rst_upd",   32'(gain_upd), 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 5'd1, I);

    // Acquire: the tick in the enabling cycle is ignored, then 16 good ticks.
    cyc(1'b1, 1'b1, 5'd1, mk(2'd1, 5'd8, 5'd12, 1'b0, 1'b1, 1'b0));
    ticks(15, 5'd1, A);
    cyc(1'b1, 1'b1, 5'd1, mk(2'd2, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0));
    ticks(7, 5'd31, S);           // errors ignored while settling
    cyc(1'b1, 1'b1, 5'd31, L);

    // Loss of lock: err==6 is not bad and breaks the run.
    ticks(3, 5'd7, L);
    ticks(1, 5'd6, L);
    ticks(3, 5'd7, L);
    cyc(1'b1, 1'b1, 5'd7, mk(2'd1, 5'd8, 5'd12, 1'b0, 1'b1, 1'b1));
    cyc(1'b1, 1'b0, 5'd0, A);

    // err==2 is good, err==3 resets the run; lock decided on tick 32.
    ticks(15, 5'd2, A);
    ticks(1, 5'd3, A);
    ticks(15, 5'd0, A);
    cyc(1'b1, 1'b1, 5'd0, mk(2'd2, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0));
    ticks(7, 5'd0, S);
    cyc(1'b1, 1'b1, 5'd0, L);

    // Gain inputs changed mid-state are not picked up.
    alpha_trk = 5'd9;
    ticks(3, 5'd0, L);

    // Disable from LOCKED, then abort an acquisition on its deciding tick.
    cyc(1'b0, 1'b0, 5'd0, mk(2'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0));
    cyc(1'b0, 1'b0, 5'd0, I);
    cyc(1'b1, 1'b0, 5'd0, mk(2'd1, 5'd8, 5'd12, 1'b0, 1'b1, 1'b0));
    ticks(15, 5'd1, A);
    cyc(1'b0, 1'b1, 5'd1, mk(2'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0));
    cyc(1'b0, 1'b0, 5'd1, I);
    cyc(1'b1, 1'b0, 5'd1, mk(2'd1, 5'd8, 5'd12, 1'b0, 1'b1, 1'b0));
    ticks(15, 5'd1, A);          // good count restarted from 0
    cyc(1'b1, 1'b1, 5'd1, mk(2'd2, 5'd9, 5'd3, 1'b0, 1'b1, 1'b0));
    ticks(3, 5'd0, S9);

    // Asynchronous reset mid-SETTLE: outputs clear before any clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_alpha", 32'(alpha_out), 32'd0);
    chk("arst_beta",  32'(beta_out), 32'd0);
    chk("arst_lock",  32'(locked), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'd0, I);

    #20;
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
